// File: rtl/echo_queue_pkg.sv
// echo_queue_pkg: rule indices and the queued request entry shared by the echo queue.
package echo_queue_pkg;
  localparam int RULE_DELAY = 0;
  localparam int RULE_RESPOND = 1;
  localparam int RULE_COUNT = 2;
  localparam int DEF_METH_W = 32;
  localparam int DEF_DATA_W = 32;
  typedef struct packed {
    logic [DEF_METH_W-1:0] meth;
    logic [DEF_DATA_W-1:0] v;
  } entry_t;
endpackage

// File: rtl/echo_queue_if.sv
// echo_queue_if: say request channel and indication_heard response channel.
interface echo_queue_if #(parameter int METH_W = 32, parameter int DATA_W = 32);
  logic say__ENA;
  logic [METH_W-1:0] say_meth;
  logic [DATA_W-1:0] say_v;
  logic say__RDY;
  logic indication_heard__ENA;
  logic [METH_W-1:0] indication_heard_meth;
  logic [DATA_W-1:0] indication_heard_v;
  logic indication_heard__RDY;
  modport master (
    output say__ENA, say_meth, say_v, indication_heard__RDY,
    input say__RDY, indication_heard__ENA, indication_heard_meth, indication_heard_v
  );
  modport slave (
    input say__ENA, say_meth, say_v, indication_heard__RDY,
    output say__RDY, indication_heard__ENA, indication_heard_meth, indication_heard_v
  );
endinterface

// File: rtl/echo_queue_fifo.sv
// echo_queue_fifo: DEPTH-entry register file; full/empty come from the occupancy count, not pointer compare.
module echo_queue_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic [W-1:0] i_data,
  input  logic i_pop,
  output logic [W-1:0] o_head,
  output logic [$clog2(DEPTH):0] o_occupancy
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0] r_occ;
  assign o_head = r_mem[r_rd_ptr];
  assign o_occupancy = r_occ;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ <= '0;
    end else begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (i_push != i_pop) r_occ <= i_push ? r_occ + (PW+1)'(1) : r_occ - (PW+1)'(1);
    end
  end
endmodule

// File: rtl/echo_queue.sv
// echo_queue: FIFO of say requests replayed in order through an output register on indication_heard.
module echo_queue
  import echo_queue_pkg::*;
#(
  parameter int METH_W = DEF_METH_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic CLK,
  input  logic RST,
  echo_queue_if.slave bus,
  input  logic [RULE_COUNT-1:0] rule_enable,
  output logic [RULE_COUNT-1:0] rule_ready,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0] heard_count
);
  localparam int OW = $clog2(DEPTH) + 1;
  logic w_say, w_delay, w_respond, w_delay_rdy, w_respond_rdy;
  logic [METH_W+DATA_W-1:0] w_head;
  logic r_out_valid;
  logic [METH_W-1:0] r_meth;
  logic [DATA_W-1:0] r_v;
  logic [CNT_W-1:0] r_count;
  // out_valid splits the two ready terms, so delay and respond never fire together
  assign w_delay_rdy = (occupancy != '0) && !r_out_valid;
  assign w_respond_rdy = r_out_valid && bus.indication_heard__RDY;
  assign bus.say__RDY = occupancy != OW'(DEPTH);
  assign w_say = bus.say__ENA && bus.say__RDY;
  assign w_delay = rule_enable[RULE_DELAY] && w_delay_rdy;
  assign w_respond = rule_enable[RULE_RESPOND] && w_respond_rdy;
  assign rule_ready = {w_respond_rdy, w_delay_rdy};
  assign bus.indication_heard__ENA = w_respond;
  assign bus.indication_heard_meth = r_meth;
  assign bus.indication_heard_v = r_v;
  assign heard_count = r_count;
  echo_queue_fifo #(.W(METH_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(CLK),
    .rst(RST),
    .i_push(w_say),
    .i_data({bus.say_meth, bus.say_v}),
    .i_pop(w_delay),
    .o_head(w_head),
    .o_occupancy(occupancy)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out_valid <= 1'b0;
      r_meth <= '0;
      r_v <= '0;
      r_count <= '0;
    end else begin
      if (w_delay) {r_out_valid, r_meth, r_v} <= {1'b1, w_head};
      else if (w_respond) r_out_valid <= 1'b0;
      if (w_respond) r_count <= r_count + CNT_W'(1);
    end
  end
endmodule
